// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of one shared byte-wide
// memory bus. Regions have different wait states, and all outputs are registered.
module mem_arbiter #(
  parameter int unsigned ROM_WAIT     = 1,
  parameter int unsigned RAM_WAIT     = 2,
  parameter int unsigned RAM_BASE_BIT = 15
) (
  input  logic        CLK,
  input  logic        RST_bar,
  input  logic        HALT,
  input  logic        FETCH_REQ,
  input  logic [15:0] FETCH_ADDR,
  output logic        FETCH_GNT,
  output logic        FETCH_VALID,
  output logic [7:0]  FETCH_DATA,
  input  logic        DATA_REQ,
  input  logic        DATA_WE,
  input  logic [15:0] DATA_ADDR,
  input  logic [7:0]  DATA_WDATA,
  output logic        DATA_GNT,
  output logic        DATA_VALID,
  output logic [7:0]  DATA_RDATA,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA_OUT,
  input  logic [7:0]  MEM_DATA_IN,
  output logic        MEM_OE_bar,
  output logic        MEM_WE_bar,
  output logic        BUSY,
  output logic        WR_ROM_ERR
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_data;
  logic        r_is_store;
  logic        r_last_data;
  logic        r_fetch_gnt, r_fetch_valid, r_data_gnt, r_data_valid;
  logic [7:0]  r_fetch_data, r_data_rdata, r_mem_data_out;
  logic [15:0] r_mem_addr;
  logic        r_oe_n, r_we_n, r_busy, r_wr_rom_err;

  // DATA wins a tie unless it was the last requester served.
  logic        w_pick_data;
  logic        w_grant;
  logic [15:0] w_addr;
  logic        w_store;
  logic        w_ram;
  logic [3:0]  w_wait;

  assign w_pick_data = DATA_REQ && (!FETCH_REQ || !r_last_data);
  assign w_grant     = !HALT && (FETCH_REQ || DATA_REQ);
  assign w_addr      = w_pick_data ? DATA_ADDR : FETCH_ADDR;
  assign w_store     = w_pick_data && DATA_WE;
  assign w_ram       = w_addr[RAM_BASE_BIT];
  assign w_wait      = w_ram ? 4'(RAM_WAIT) : 4'(ROM_WAIT);

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      r_is_data      <= 1'b0;
      r_is_store     <= 1'b0;
      r_last_data    <= 1'b0;
      r_fetch_gnt    <= 1'b0;
      r_fetch_valid  <= 1'b0;
      r_data_gnt     <= 1'b0;
      r_data_valid   <= 1'b0;
      r_fetch_data   <= 8'd0;
      r_data_rdata   <= 8'd0;
      r_mem_data_out <= 8'd0;
      r_mem_addr     <= 16'd0;
      r_oe_n         <= 1'b1;
      r_we_n         <= 1'b1;
      r_busy         <= 1'b0;
      r_wr_rom_err   <= 1'b0;
    end else begin
      r_fetch_gnt   <= 1'b0;
      r_data_gnt    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state     <= ACCESS;
            r_busy      <= 1'b1;
            r_is_data   <= w_pick_data;
            r_is_store  <= w_store;
            r_last_data <= w_pick_data;
            r_fetch_gnt <= !w_pick_data;
            r_data_gnt  <= w_pick_data;
            r_mem_addr  <= w_addr;
            r_cnt       <= w_wait;
            if (w_store) begin
              r_mem_data_out <= DATA_WDATA;
              r_oe_n         <= 1'b1;
              r_we_n         <= !w_ram;
              if (!w_ram) r_wr_rom_err <= 1'b1;
            end else begin
              r_oe_n <= 1'b0;
              r_we_n <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            // Release the strobe one cycle early so the last cycle holds data.
            if (r_cnt == 4'd1) r_we_n <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            if (r_is_data) begin
              r_data_valid <= 1'b1;
              if (!r_is_store) r_data_rdata <= MEM_DATA_IN;
            end else begin
              r_fetch_valid <= 1'b1;
              r_fetch_data  <= MEM_DATA_IN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FETCH_GNT    = r_fetch_gnt;
  assign FETCH_VALID  = r_fetch_valid;
  assign FETCH_DATA   = r_fetch_data;
  assign DATA_GNT     = r_data_gnt;
  assign DATA_VALID   = r_data_valid;
  assign DATA_RDATA   = r_data_rdata;
  assign MEM_ADDR     = r_mem_addr;
  assign MEM_DATA_OUT = r_mem_data_out;
  assign MEM_OE_bar   = r_oe_n;
  assign MEM_WE_bar   = r_we_n;
  assign BUSY         = r_busy;
  assign WR_ROM_ERR   = r_wr_rom_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand-built sequences for
// tie-break, reset abort and HALT. A monitor compares each VALID against a queue.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_bar = 1'b0;
  logic        HALT = 1'b0;
  logic        FETCH_REQ = 1'b0;
  logic [15:0] FETCH_ADDR = 16'd0;
  logic        FETCH_GNT, FETCH_VALID;
  logic [7:0]  FETCH_DATA;
  logic        DATA_REQ = 1'b0;
  logic        DATA_WE = 1'b0;
  logic [15:0] DATA_ADDR = 16'd0;
  logic [7:0]  DATA_WDATA = 8'd0;
  logic        DATA_GNT, DATA_VALID;
  logic [7:0]  DATA_RDATA;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DATA_OUT;
  logic [7:0]  MEM_DATA_IN;
  logic        MEM_OE_bar, MEM_WE_bar, BUSY, WR_ROM_ERR;

  mem_arbiter #(.ROM_WAIT(1), .RAM_WAIT(2), .RAM_BASE_BIT(15)) dut (
    .CLK(CLK), .RST_bar(RST_bar), .HALT(HALT),
    .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR), .FETCH_GNT(FETCH_GNT),
    .FETCH_VALID(FETCH_VALID), .FETCH_DATA(FETCH_DATA),
    .DATA_REQ(DATA_REQ), .DATA_WE(DATA_WE), .DATA_ADDR(DATA_ADDR),
    .DATA_WDATA(DATA_WDATA), .DATA_GNT(DATA_GNT), .DATA_VALID(DATA_VALID),
    .DATA_RDATA(DATA_RDATA), .MEM_ADDR(MEM_ADDR), .MEM_DATA_OUT(MEM_DATA_OUT),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_OE_bar(MEM_OE_bar), .MEM_WE_bar(MEM_WE_bar),
    .BUSY(BUSY), .WR_ROM_ERR(WR_ROM_ERR)
  );

  always #5 CLK = ~CLK;

  // Memory returns a simple hash of the address.
  assign MEM_DATA_IN = MEM_ADDR[7:0] ^ MEM_ADDR[15:8] ^ 8'hB5;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  data;    // expected FETCH_DATA / DATA_RDATA after VALID
    int          lat;     // edges from GNT to VALID
    int          oe_low;
    int          we_low;
    bit          err;     // expected WR_ROM_ERR at VALID
  } vec_t;

  vec_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   oe_cnt = 0, we_cnt = 0, bus_bad = 0, n_txn = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks bus activity per access and scores each VALID.
  always @(negedge CLK) begin
    if (!RST_bar) begin
      oe_cnt = 0; we_cnt = 0; bus_bad = 0;
    end else begin
      if (FETCH_GNT || DATA_GNT) begin
        gnt_cyc = cyc; oe_cnt = 0; we_cnt = 0; bus_bad = 0;
      end
      if (BUSY) begin
        if (!MEM_OE_bar) oe_cnt++;
        if (!MEM_WE_bar) we_cnt++;
        if (sb.size() > 0) begin
          if (MEM_ADDR !== sb[0].addr) bus_bad++;
          if (sb[0].we && MEM_DATA_OUT !== sb[0].wdata) bus_bad++;
        end
      end
      if (FETCH_VALID || DATA_VALID) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {30'd0, FETCH_VALID, DATA_VALID}, 32'd0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          n_txn++;
          chk("valid_which", {30'd0, FETCH_VALID, DATA_VALID}, e.is_data ? 32'd1 : 32'd2);
          chk("latency", 32'(cyc - gnt_cyc), 32'(e.lat));
          chk("oe_low_cycles", 32'(oe_cnt), 32'(e.oe_low));
          chk("we_low_cycles", 32'(we_cnt), 32'(e.we_low));
          chk("read_data", 32'(e.is_data ? DATA_RDATA : FETCH_DATA), 32'(e.data));
          chk("bus_addr_wdata", 32'(bus_bad), 32'd0);
          chk("wr_rom_err", 32'(WR_ROM_ERR), 32'(e.err));
          chk("busy_at_valid", 32'(BUSY), 32'd0);
          $display("txn %0d: %s %s addr=%04h rd=%02h lat=%0d oe=%0d we=%0d err=%0b",
                   n_txn, e.is_data ? "DATA " : "FETCH", e.we ? "st" : "ld", e.addr,
                   e.is_data ? DATA_RDATA : FETCH_DATA, cyc - gnt_cyc, oe_cnt, we_cnt, WR_ROM_ERR);
        end
      end
    end
  end

  task automatic wait_gnt(input bit is_data, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK); #1;
      seen = is_data ? DATA_GNT : FETCH_GNT;
    end
    chk({tag, "_gnt"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_sb(input int target, input string tag);
    for (int i = 0; i < 60 && sb.size() > target; i++) begin
      @(negedge CLK); #1;
    end
    chk({tag, "_done"}, 32'(sb.size()), 32'(target));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.is_data) begin
      DATA_REQ = 1'b1; DATA_WE = v.we; DATA_ADDR = v.addr; DATA_WDATA = v.wdata;
    end else begin
      FETCH_REQ = 1'b1; FETCH_ADDR = v.addr;
    end
    sb.push_back(v);
    wait_gnt(v.is_data, tag);
    DATA_REQ = 1'b0; FETCH_REQ = 1'b0;
    wait_sb(0, tag);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_no_gnt"}, 32'(FETCH_GNT | DATA_GNT), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t vd, vf;
    //           data we  addr      wdata  data  lat oe we err
    tbl[0] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 2, 2, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h8001, 8'h3C, 8'h00, 3, 0, 2, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h8001, 8'h00, 8'h34, 3, 3, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'hFF00, 8'h00, 8'h4A, 3, 3, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h7FFF, 8'h00, 8'h35, 2, 2, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h8055, 8'h00, 8'h60, 3, 3, 0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0100, 8'h77, 8'h60, 2, 0, 0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 16'h00C3, 8'h00, 8'h76, 2, 2, 0, 1'b1};

    // Reset state, observed while reset is still held.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_oe", 32'(MEM_OE_bar), 32'd1);
    chk("rst_we", 32'(MEM_WE_bar), 32'd1);
    chk("rst_gnt_valid", {28'd0, FETCH_GNT, DATA_GNT, FETCH_VALID, DATA_VALID}, 32'd0);
    chk("rst_busy_err", {30'd0, BUSY, WR_ROM_ERR}, 32'd0);
    chk("rst_addr", 32'(MEM_ADDR), 32'd0);
    chk("rst_dout", 32'(MEM_DATA_OUT), 32'd0);
    chk("rst_rdata", {16'd0, FETCH_DATA, DATA_RDATA}, 32'd0);
    @(negedge CLK); RST_bar = 1'b1; #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a RAM store aborts it; held request is re-granted.
    DATA_REQ = 1'b1; DATA_WE = 1'b1; DATA_ADDR = 16'h8004; DATA_WDATA = 8'h11;
    wait_gnt(1'b1, "abort");
    @(negedge CLK); #1;
    chk("abort_we_active", 32'(MEM_WE_bar), 32'd0);
    #2 RST_bar = 1'b0;
    #1;
    chk("abort_we_async", 32'(MEM_WE_bar), 32'd1);
    chk("abort_oe_async", 32'(MEM_OE_bar), 32'd1);
    chk("abort_busy_async", 32'(BUSY), 32'd0);
    chk("abort_err_cleared", 32'(WR_ROM_ERR), 32'd0);
    chk("abort_addr_cleared", 32'(MEM_ADDR), 32'd0);
    chk("abort_rdata_cleared", 32'(DATA_RDATA), 32'd0);
    #8 RST_bar = 1'b1;
    vd = '{1'b1, 1'b1, 16'h8004, 8'h11, 8'h00, 3, 0, 2, 1'b0};
    sb.push_back(vd);
    wait_gnt(1'b1, "regrant");
    DATA_REQ = 1'b0;
    wait_sb(0, "regrant");

    // Both requests held from a fresh reset: DATA, FETCH, DATA, FETCH.
    RST_bar = 1'b0;
    @(negedge CLK); RST_bar = 1'b1; #1;
    vd = '{1'b1, 1'b0, 16'h8002, 8'h00, 8'h37, 3, 3, 0, 1'b0};
    vf = '{1'b0, 1'b0, 16'h0020, 8'h00, 8'h95, 2, 2, 0, 1'b0};
    DATA_REQ = 1'b1; DATA_WE = 1'b0; DATA_ADDR = vd.addr;
    FETCH_REQ = 1'b1; FETCH_ADDR = vf.addr;
    sb.push_back(vd); sb.push_back(vf); sb.push_back(vd); sb.push_back(vf);
    wait_sb(0, "alternate");
    DATA_REQ = 1'b0; FETCH_REQ = 1'b0;
    repeat (2) begin
      @(negedge CLK); #1;
      chk_quiet("idle_after_alt");
    end
    chk("idle_addr_hold", 32'(MEM_ADDR), 32'h0020);
    chk("idle_strobes", {30'd0, MEM_OE_bar, MEM_WE_bar}, 32'd3);

    // HALT raised during an access: current access finishes, then nothing until HALT falls.
    vd = '{1'b1, 1'b0, 16'h0030, 8'h00, 8'h85, 2, 2, 0, 1'b0};
    vf = '{1'b0, 1'b0, 16'h8010, 8'h00, 8'h25, 3, 3, 0, 1'b0};
    DATA_REQ = 1'b1; DATA_ADDR = vd.addr;
    FETCH_REQ = 1'b1; FETCH_ADDR = vf.addr;
    sb.push_back(vd);
    wait_gnt(1'b1, "halt_first");
    HALT = 1'b1;
    sb.push_back(vf);
    wait_sb(1, "halt_drain");
    repeat (5) begin
      @(negedge CLK); #1;
      chk_quiet("halted");
    end
    HALT = 1'b0;
    @(negedge CLK); #1;
    chk("halt_release_gnt", {30'd0, FETCH_GNT, DATA_GNT}, 32'd2);
    DATA_REQ = 1'b0; FETCH_REQ = 1'b0;
    wait_sb(0, "halt_release");

    // A request withdrawn before it could be granted leaves no trace.
    HALT = 1'b1; FETCH_REQ = 1'b1; FETCH_ADDR = 16'h1234;
    repeat (2) @(negedge CLK);
    #1 FETCH_REQ = 1'b0; HALT = 1'b0;
    repeat (4) begin
      @(negedge CLK); #1;
      chk_quiet("dropped_req");
    end
    chk("dropped_addr_hold", 32'(MEM_ADDR), 32'h8010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ROM_WAIT, 1, extra wait cycles for a ROM-region access (0..15).
- RAM_WAIT, 2, extra wait cycles for a RAM-region access (0..15).
- RAM_BASE_BIT, 15, address bit that selects RAM (1) or ROM (0).
REQ-002 Ports, one per line: name, direction, width, meaning:
- CLK, in, 1, system clock; all state changes on its rising edge.
- RST_bar, in, 1, asynchronous active-low reset.
- HALT, in, 1, when high, no new grant is issued.
- FETCH_REQ, in, 1, instruction-fetch request; held until FETCH_GNT.
- FETCH_ADDR, in, 16, fetch address.
- FETCH_GNT, out, 1, one-cycle pulse; fetch request accepted.
- FETCH_VALID, out, 1, one-cycle pulse; FETCH_DATA is valid.
- FETCH_DATA, out, 8, fetched byte.
- DATA_REQ, in, 1, load/store request; held until DATA_GNT.
- DATA_WE, in, 1, 1 = store, 0 = load.
- DATA_ADDR, in, 16, load/store address.
- DATA_WDATA, in, 8, store data.
- DATA_GNT, out, 1, one-cycle pulse; data request accepted.
- DATA_VALID, out, 1, one-cycle pulse; load data valid or store complete.
- DATA_RDATA, out, 8, loaded byte.
- MEM_ADDR, out, 16, memory address bus.
- MEM_DATA_OUT, out, 8, memory write data.
- MEM_DATA_IN, in, 8, memory read data.
- MEM_OE_bar, out, 1, memory output enable, active low.
- MEM_WE_bar, out, 1, memory write enable, active low.
- BUSY, out, 1, high while an access is in progress.
- WR_ROM_ERR, out, 1, sticky flag: a store targeted the ROM region.
REQ-003 Every output SHALL be driven from a register.

Function
REQ-004 States SHALL be IDLE and ACCESS.
REQ-005 In IDLE with HALT low and at least one request high, the arbiter SHALL, on the clock edge:
- grant exactly one requester;
- pulse that requester's GNT for one cycle;
- latch its address, direction and write data;
- load the wait counter with ROM_WAIT or RAM_WAIT according to address bit RAM_BASE_BIT;
- enter ACCESS.
REQ-006 Arbitration on simultaneous requests SHALL alternate. The requester not granted last wins. After reset, DATA wins the first tie.
REQ-007 A request that drops before it is granted SHALL be ignored. No grant, no valid, no state change.
REQ-008 In ACCESS:
- MEM_ADDR SHALL equal the latched address.
- A load or fetch SHALL hold MEM_OE_bar low and MEM_WE_bar high.
- A store SHALL hold MEM_OE_bar high and MEM_DATA_OUT at the latched data.
- The wait counter SHALL decrement by one per cycle while it is non-zero.
REQ-009 For a store to RAM, MEM_WE_bar SHALL be low in every ACCESS cycle except the last. The final cycle is a data-hold cycle with MEM_WE_bar high. With a wait of 0, MEM_WE_bar SHALL stay low for the single ACCESS cycle.
REQ-010 On the edge where the counter is 0 in ACCESS, the arbiter SHALL:
- capture MEM_DATA_IN into FETCH_DATA or DATA_RDATA (reads only);
- pulse the matching VALID for one cycle;
- return to IDLE.
REQ-011 Latency: with GNT at edge n, VALID SHALL occur at edge n+1+W, where W is the wait for that region. Back-to-back accesses SHALL be separated by at least one IDLE cycle.
REQ-012 A store to the ROM region SHALL:
- never assert MEM_WE_bar;
- still complete with DATA_VALID after ROM_WAIT;
- set WR_ROM_ERR, which stays set until reset.
REQ-013 In IDLE:
- MEM_OE_bar and MEM_WE_bar SHALL be high;
- MEM_ADDR SHALL hold its last value;
- BUSY SHALL be low.
BUSY SHALL be high in ACCESS.
REQ-014 HALT SHALL block new grants only. An access already in ACCESS SHALL complete normally.
REQ-015 FETCH_DATA and DATA_RDATA SHALL hold their last captured values between accesses.

Reset
REQ-016 While RST_bar is low, the arbiter SHALL immediately, without waiting for a clock edge:
- set the state to IDLE;
- set MEM_WE_bar and MEM_OE_bar high;
- clear all GNT and VALID outputs and BUSY;
- set MEM_ADDR, MEM_DATA_OUT, FETCH_DATA and DATA_RDATA to 0;
- clear WR_ROM_ERR;
- clear the wait counter;
- clear the tie-break memory so DATA wins next.
REQ-017 Reset asserted during an access SHALL abort it with no VALID pulse. After release, a still-held request SHALL be re-arbitrated from IDLE.

Verification
REQ-018 Fetch from 0x0010 with ROM_WAIT=1 and memory returning 0xA5 -> FETCH_GNT at edge n, MEM_OE_bar low for 2 cycles, FETCH_VALID at n+2 with FETCH_DATA=0xA5.
REQ-019 Store of 0x3C to 0x8001 with RAM_WAIT=2 -> MEM_WE_bar low for 2 cycles then high for 1, MEM_DATA_OUT=0x3C throughout, DATA_VALID at n+3, WR_ROM_ERR stays 0.
REQ-020 FETCH_REQ and DATA_REQ held together from reset -> grants in the order DATA, FETCH, DATA, FETCH, with each VALID preceding the next GNT.
REQ-021 Store to 0x0100 -> MEM_WE_bar never low, DATA_VALID after ROM_WAIT, WR_ROM_ERR=1 until RST_bar low.
REQ-022 RST_bar pulsed low mid-way through a RAM store -> MEM_WE_bar high with no clock edge, no DATA_VALID; after release, the held DATA_REQ is granted again.
REQ-023 HALT raised during ACCESS with both requests pending -> the current VALID still fires, then no GNT while HALT=1; the first GNT appears the cycle after HALT falls.
